pipe_arbiter: RTL and testbench
===============================

PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 5, meaning the payload width per requester.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning the maximum consecutive transfers per grant (used only under PIPE_ARB_BURST_EN).
REQ-004 SHALL have port clk_i  input  1  clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_val_i  input  NUM_REQ  per-requester valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ*DATA_W  per-requester payload, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_rdy_o  output  NUM_REQ  per-requester ready, at most one bit set.
REQ-009 SHALL have port out_val_o  output  1  downstream pipeline valid.
REQ-010 SHALL have port out_data_o  output  DATA_W  granted payload.
REQ-011 SHALL have port out_src_o  output  $clog2(NUM_REQ)  index of the requester that supplied out_data_o.
REQ-012 SHALL have port out_rdy_i  input  1  downstream pipeline ready.

Function
REQ-013 SHALL define advance = !out_val_o || out_rdy_i; the output register loads only when advance is 1.
REQ-014 SHALL select grant g combinationally as the first set req_val_i bit searching from last_grant+1 upward, wrapping from NUM_REQ-1 to 0.
REQ-015 SHALL drive req_rdy_o[g] = advance when a grant exists; all other req_rdy_o bits SHALL be 0. req_rdy_o may depend on req_val_i.
REQ-016 SHALL treat a transfer as req_val_i[g] && req_rdy_o[g]; on a transfer, out_data_o <= payload g, out_src_o <= g, out_val_o <= 1 on the next edge (latency 1 cycle).
REQ-017 SHALL clear out_val_o on an edge where advance is 1 and no transfer occurs; out_data_o and out_src_o SHALL then hold.
REQ-018 SHALL hold out_val_o, out_data_o and out_src_o stable while out_val_o && !out_rdy_i; no requester is readied in that cycle.
REQ-019 SHALL update last_grant <= g only on a transfer.
REQ-020 SHALL sustain one transfer per cycle when out_rdy_i is held at 1 (no bubbles).
REQ-021 SHALL, when all requesters are continuously valid, serve them in the order 0,1,...,NUM_REQ-1,0 (without PIPE_ARB_BURST_EN).

Reset
REQ-022 SHALL, while reset_n_i is 0, force out_val_o=0, out_data_o=0, out_src_o=0, last_grant=NUM_REQ-1 (requester 0 has first priority), FSM=ARB, burst count=0.
REQ-023 SHALL drive req_rdy_o=0 while reset_n_i is 0; a payload held in the output register when reset asserts mid-operation SHALL be discarded.

Configuration
REQ-024 SHALL support macro PIPE_ARB_BURST_EN.
REQ-025 With PIPE_ARB_BURST_EN defined: FSM states ARB and BURST; ARB->BURST on a transfer with count=1; in BURST, g SHALL be forced to the locked requester; BURST->ARB when req_val_i[locked] is 0 in an advance cycle, or on the transfer that brings count to BURST_LEN; a stall (advance=0) SHALL NOT change count or state.
REQ-026 Without PIPE_ARB_BURST_EN: the FSM and count SHALL NOT exist, and arbitration SHALL occur on every transfer per REQ-014.

Structure
REQ-027 SHALL take the FSM state enum (ARB, BURST) and the default parameter constants from pipeFlow_pkg.
REQ-028 SHALL place the round-robin search in a single sub-module rr_pick (inputs: request vector and last_grant; outputs: valid and index), with the handshake, output register and FSM in pipe_arbiter.

Verification
REQ-029 Reset: reset_n_i=0 for 3 cycles with all req_val_i=1 -> out_val_o=0 and req_rdy_o=0; after release the first transfer comes from src 0.
REQ-030 Round-robin: req_val_i=4'b1111, out_rdy_i=1, 8 cycles, no macro -> out_src_o sequence 0,1,2,3,0,1,2,3 with no bubbles.
REQ-031 Backpressure: out_rdy_i=0 for 5 cycles while out_val_o=1 with data 5'h1A -> out_data_o stays 5'h1A, req_rdy_o=0; on release the next src is (last+1) mod 4.
REQ-032 Sparse/wrap: only req_val_i[3] and [1] set, last_grant=3 -> grants 1,3,1,3.
REQ-033 Burst (PIPE_ARB_BURST_EN, BURST_LEN=4): all valid -> src 0 x4, 1 x4, 2 x4; dropping req_val_i[1] after 2 transfers -> src 1 x2, then src 2.
REQ-034 Mid-operation reset: assert reset_n_i while out_val_o=1 and out_rdy_i=0 -> out_val_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeFlow_pkg.sv
// Shared constants and FSM encoding for the pipelined round-robin arbiter.
package pipeFlow_pkg;

  localparam int PA_NUM_REQ   = 4;
  localparam int PA_DATA_W    = 5;
  localparam int PA_BURST_LEN = 4;

  // Burst FSM encoding; only instantiated when the burst option is compiled in.
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pipe_arbiter_rr_pick.sv
// Round-robin search: first set request strictly after last, wrapping at N-1.
// Purely combinational, no backpressure of its own.
module rr_pick
  import pipeFlow_pkg::*;
#(
  parameter int N     = PA_NUM_REQ,
  parameter int IDX_W = $clog2(PA_NUM_REQ)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int c;
    c   = 0;
    vld = 1'b0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(last) + i) % N;
      if (req[c]) begin
        vld = 1'b1;
        idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter into a registered pipeline stage; 1-cycle latency, stalls when out_rdy_i low.
// Optional PIPE_ARB_BURST_EN locks the grant for up to BURST_LEN back-to-back transfers.
module pipe_arbiter
  import pipeFlow_pkg::*;
#(
  parameter int NUM_REQ   = PA_NUM_REQ,
  parameter int DATA_W    = PA_DATA_W,
  parameter int BURST_LEN = PA_BURST_LEN
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [NUM_REQ-1:0]          req_val_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_rdy_o,
  output logic                        out_val_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [$clog2(NUM_REQ)-1:0]  out_src_o,
  input  logic                        out_rdy_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || BURST_LEN < 1) begin : g_bad_cfg
      $error("pipe_arbiter: unsupported NUM_REQ/DATA_W/BURST_LEN");
    end
  endgenerate

  logic             advance;
  logic             xfer;
  logic             grant_vld;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  assign advance = !out_val_o || out_rdy_i;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req_val_i),
    .last (last_grant),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

`ifdef PIPE_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e       state;
  logic [CNT_W-1:0] burst_cnt;

  // While bursting, the locked requester is the last one granted.
  always_comb begin
    grant     = pick_idx;
    grant_vld = pick_vld;
    if (state == BURST) begin
      grant     = last_grant;
      grant_vld = req_val_i[last_grant];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ARB;
      burst_cnt <= '0;
    end else if (advance) begin
      case (state)
        ARB: begin
          if (xfer && BURST_LEN > 1) begin
            state     <= BURST;
            burst_cnt <= CNT_W'(1);
          end
        end
        BURST: begin
          if (!req_val_i[last_grant]) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else if (xfer) begin
            if (burst_cnt == CNT_W'(BURST_LEN - 1)) begin
              state     <= ARB;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end
`else
  assign grant     = pick_idx;
  assign grant_vld = pick_vld;
`endif

  // Ready is withheld during reset even though advance is high then.
  always_comb begin
    req_rdy_o = '0;
    if (reset_n_i && grant_vld && advance) begin
      req_rdy_o[grant] = 1'b1;
    end
  end

  assign xfer = |(req_val_i & req_rdy_o);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_val_o  <= 1'b0;
      out_data_o <= '0;
      out_src_o  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (advance) begin
      out_val_o <= xfer;
      if (xfer) begin
        out_data_o <= req_data_i[int'(grant)*DATA_W +: DATA_W];
        out_src_o  <= grant;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_pipe_arbiter.sv
// Scoreboarded bench for pipe_arbiter: sources with per-requester item counts, expected order queued per test.
module tb_pipe_arbiter;

  localparam int NR = 4;
  localparam int DW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_val;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_rdy;
  logic            out_val;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_rdy;

  always #5 clk = ~clk;

  pipe_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .BURST_LEN (4)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .req_val_i  (req_val),
    .req_data_i (req_data),
    .req_rdy_o  (req_rdy),
    .out_val_o  (out_val),
    .out_data_o (out_data),
    .out_src_o  (out_src),
    .out_rdy_i  (out_rdy)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          sb[$];
  int            pop_cyc[$];
  int            remaining[NR];
  logic [DW-1:0] pay[NR];
  int            cyc;
  int            n_checks;
  int            n_fail;

  task automatic expect_src(input int s);
    exp_t e;
    e.src = 2'(s);
    e.dat = pay[s];
    sb.push_back(e);
  endtask

  // One cycle: drive sources, sample both handshakes just before the edge, then advance.
  task automatic step();
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      req_val[i]             = (remaining[i] > 0);
      req_data[i*DW +: DW]   = pay[i];
    end
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_val[i] && req_rdy[i]) remaining[i] = remaining[i] - 1;
    end
    if (out_val && out_rdy) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got src=%0d data=%h, required no output", out_src, out_data);
      end else begin
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if (out_src !== e.src || out_data !== e.dat) begin
          n_fail++;
          $display("FAIL out_pop: got src=%0d data=%h, required src=%0d data=%h",
                   out_src, out_data, e.src, e.dat);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries left after %0d cycles, required 0", name, sb.size(), k);
      sb.delete();
    end
  endtask

  task automatic set_sources(input int r0, input int r1, input int r2, input int r3);
    remaining[0] = r0;
    remaining[1] = r1;
    remaining[2] = r2;
    remaining[3] = r3;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    pay[0] = 5'h05; pay[1] = 5'h0A; pay[2] = 5'h11; pay[3] = 5'h16;
    set_sources(1, 1, 1, 1);
    repeat (3) begin
      step();
      n_checks++;
      if (out_val !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_val: got %b, required 0", out_val);
      end
      n_checks++;
      if (req_rdy !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_req_rdy: got %b, required 0000", req_rdy);
      end
      n_checks++;
      if (out_src !== 2'd0 || out_data !== 5'h00) begin
        n_fail++;
        $display("FAIL reset_out_regs: got src=%0d data=%h, required src=0 data=00", out_src, out_data);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) expect_src(i);
    drain("reset_release", 20);
  endtask

  task automatic test_round_robin();
    out_rdy = 1'b1;
    pay[0] = 5'h01; pay[1] = 5'h12; pay[2] = 5'h0B; pay[3] = 5'h1C;
    set_sources(2, 2, 2, 2);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) expect_src(i);
    end
    pop_cyc.delete();
    drain("round_robin", 30);
    n_checks++;
    if (pop_cyc.size() != 8) begin
      n_fail++;
      $display("FAIL rr_no_bubbles: got %0d outputs, required 8", pop_cyc.size());
    end else if (pop_cyc[7] - pop_cyc[0] != 7) begin
      n_fail++;
      $display("FAIL rr_no_bubbles: got span %0d cycles, required 7", pop_cyc[7] - pop_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    pay[0] = 5'h1A; pay[1] = 5'h03; pay[2] = 5'h0C; pay[3] = 5'h15;
    set_sources(1, 1, 1, 1);
    step();
    repeat (5) begin
      step();
      n_checks++;
      if (out_val !== 1'b1 || out_data !== 5'h1A || out_src !== 2'd0) begin
        n_fail++;
        $display("FAIL stall_hold: got val=%b src=%0d data=%h, required val=1 src=0 data=1a",
                 out_val, out_src, out_data);
      end
      n_checks++;
      if (req_rdy !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_req_rdy: got %b, required 0000", req_rdy);
      end
    end
    out_rdy = 1'b1;
    for (int i = 0; i < NR; i++) expect_src(i);
    drain("backpressure", 20);
  endtask

  task automatic test_sparse_wrap();
    out_rdy = 1'b1;
    pay[0] = 5'h00; pay[1] = 5'h07; pay[2] = 5'h00; pay[3] = 5'h19;
    set_sources(0, 2, 0, 2);
`ifdef PIPE_ARB_BURST_EN
    expect_src(1); expect_src(1); expect_src(3); expect_src(3);
`else
    expect_src(1); expect_src(3); expect_src(1); expect_src(3);
`endif
    drain("sparse_wrap", 20);
  endtask

`ifdef PIPE_ARB_BURST_EN
  task automatic test_burst();
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    set_sources(0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    pay[0] = 5'h02; pay[1] = 5'h0D; pay[2] = 5'h14; pay[3] = 5'h1F;
    set_sources(4, 4, 4, 4);
    for (int i = 0; i < NR; i++) begin
      repeat (4) expect_src(i);
    end
    drain("burst_full", 40);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_sources(0, 2, 2, 0);
    expect_src(1); expect_src(1); expect_src(2); expect_src(2);
    drain("burst_drop", 20);
  endtask
`endif

  task automatic test_mid_reset();
    out_rdy = 1'b0;
    pay[2] = 5'h0F;
    set_sources(0, 0, 1, 0);
    step();
    step();
    n_checks++;
    if (out_val !== 1'b1 || out_data !== 5'h0F) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got val=%b data=%h, required val=1 data=0f", out_val, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got out_val=%b, required 0", out_val);
    end
    n_checks++;
    if (req_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_req_rdy: got %b, required 0000", req_rdy);
    end
    sb.delete();
    set_sources(0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    step();
    n_checks++;
    if (out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_discard: got out_val=%b, required 0", out_val);
    end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    out_rdy  = 1'b0;
    req_val  = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 0;
      pay[i]       = '0;
    end
    #1;
    test_reset();
`ifdef PIPE_ARB_BURST_EN
    test_backpressure();
    test_sparse_wrap();
    test_burst();
`else
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
`endif
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
